cpumc_cmd_engine: RTL

- Byte-stream command engine that sits directly upstream of the CPU memory controller and drives its addr/wr/din bus.
- Used by the debug/loader path (UART RX/TX FIFOs) to bulk-load PRG-ROM and RAM, and to read them back, while the CPU is halted.
- Parses opcode packets from an input byte stream and issues single-byte memory accesses. It returns read data and status on an output byte stream.

---
 rtl/cpumc_cmd_engine.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpumc_cmd_engine.sv
// ---------------------------------------------------------------------------
// cpumc_cmd_engine
//
// Byte-stream command engine placed in front of the CPU memory controller.
// The debug/loader path feeds it opcode packets from the UART RX FIFO. It
// turns them into single-byte memory reads and writes. Read data and status
// bytes go back out towards the UART TX FIFO.
//
// Packets (multi-byte fields little-endian):
//   0x01 WRITE  : addr_lo, addr_hi, cnt_lo, cnt_hi, cnt data bytes
//   0x02 READ   : addr_lo, addr_hi, cnt_lo, cnt_hi  -> cnt response bytes
//   0x03 STATUS : no operands                       -> {7'b0, err}
//   other       : sets err, only the opcode byte is consumed
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   in_data/valid/ready   command byte stream (valid/ready handshake)
//   out_data/valid/ready  response byte stream (valid/ready handshake)
//   mem_addr/wr/din       memory controller request bus
//   mem_dout              read data, valid the cycle after mem_addr
//   mem_invalid           controller flags the current mem_addr as invalid
//   busy                  engine is working on a packet
//   err                   sticky error, cleared when a STATUS byte is taken
//
// Parameter:
//   TIMEOUT_CYCLES        idle cycles allowed mid-packet (0 = no timeout)
// ---------------------------------------------------------------------------
module cpumc_cmd_engine #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] mem_addr,
    output logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_invalid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_DATA,
        S_RD_OUT,
        S_STAT_OUT
    } state_t;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    // The idle counter runs 0..TIMEOUT_CYCLES-1. The timeout fires on the
    // cycle after the last count if no byte has arrived by then.
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t         r_state;
    state_t         w_next_state;

    logic           r_live;
    logic           r_is_read;
    logic [1:0]     r_idx;
    logic [15:0]    r_addr;
    logic [15:0]    r_cnt;
    logic [TW-1:0]  r_tmo;

    logic [7:0]     r_out_data;
    logic           r_out_valid;
    logic [15:0]    r_mem_addr;
    logic           r_mem_wr;
    logic [7:0]     r_mem_din;
    logic           r_err;

    logic           w_accept;
    logic           w_out_accept;
    logic           w_in_window;
    logic           w_tmo_hit;
    logic           w_err_set;
    logic           w_err_clr;
    logic [15:0]    w_hdr_cnt;

    assign w_accept     = in_valid && in_ready;
    assign w_out_accept = r_out_valid && out_ready;
    assign w_in_window  = (r_state == S_HDR) || (r_state == S_WR_DATA);
    assign w_tmo_hit    = TMO_EN && w_in_window && !w_accept && (r_tmo == TMO_LAST);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wr    = r_mem_wr;
    assign mem_din   = r_mem_din;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, the input handshake and the error set/clear events.
    // The count completed by the final header byte is assembled here so that
    // a zero-length transfer can go straight back to IDLE.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        w_hdr_cnt    = {in_data, r_cnt[7:0]};

        case (r_state)
            S_IDLE: begin
                in_ready = r_live;
                if (w_accept) begin
                    if (in_data == OP_WRITE || in_data == OP_READ) begin
                        w_next_state = S_HDR;
                    end else if (in_data == OP_STATUS) begin
                        w_next_state = S_STAT_OUT;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_HDR: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (r_idx == 2'd3) begin
                        if (w_hdr_cnt == 16'd0) begin
                            w_next_state = S_IDLE;
                        end else if (r_is_read) begin
                            w_next_state = S_RD_ADDR;
                        end else begin
                            w_next_state = S_WR_DATA;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            S_WR_DATA: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (r_cnt == 16'd1) begin
                        w_next_state = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            S_RD_ADDR: begin
                w_next_state = S_RD_DATA;
                if (mem_invalid) begin
                    w_err_set = 1'b1;
                end
            end
            S_RD_DATA: begin
                w_next_state = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (w_out_accept) begin
                    w_next_state = (r_cnt == 16'd1) ? S_IDLE : S_RD_ADDR;
                end
            end
            S_STAT_OUT: begin
                if (w_out_accept) begin
                    w_next_state = S_IDLE;
                    w_err_clr    = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // A write is checked while its pulse is on the bus, and that can be
        // the first IDLE cycle after the final data byte.
        if (r_mem_wr && mem_invalid) begin
            w_err_set = 1'b1;
        end
    end

    // Datapath: header capture, address/count stepping, the memory request
    // bus, the response byte and the sticky error. mem_wr drops every cycle
    // unless a data byte is taken, so each byte gives one single-cycle pulse.
    // r_live holds in_ready low until the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live      <= 1'b0;
            r_is_read   <= 1'b0;
            r_idx       <= 2'd0;
            r_addr      <= 16'd0;
            r_cnt       <= 16'd0;
            r_tmo       <= '0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wr    <= 1'b0;
            r_mem_din   <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_mem_wr <= 1'b0;
            r_err    <= w_err_set | (r_err & ~w_err_clr);

            if (TMO_EN && w_in_window && !w_accept && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx     <= 2'd0;
                        r_is_read <= (in_data == OP_READ);
                        if (in_data == OP_STATUS) begin
                            r_out_data  <= {7'b0, r_err};
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_addr[7:0]  <= in_data;
                            2'd1: r_addr[15:8] <= in_data;
                            2'd2: r_cnt[7:0]   <= in_data;
                            default: begin
                                r_cnt[15:8] <= in_data;
                                if (w_next_state == S_RD_ADDR) begin
                                    r_mem_addr <= r_addr;
                                end
                            end
                        endcase
                    end
                end
                S_WR_DATA: begin
                    if (w_accept) begin
                        r_mem_addr <= r_addr;
                        r_mem_din  <= in_data;
                        r_mem_wr   <= 1'b1;
                        r_addr     <= r_addr + 16'd1;
                        r_cnt      <= r_cnt - 16'd1;
                    end
                end
                S_RD_DATA: begin
                    r_out_data  <= mem_dout;
                    r_out_valid <= 1'b1;
                end
                S_RD_OUT: begin
                    if (w_out_accept) begin
                        r_out_valid <= 1'b0;
                        r_addr      <= r_addr + 16'd1;
                        r_cnt       <= r_cnt - 16'd1;
                        if (r_cnt != 16'd1) begin
                            r_mem_addr <= r_addr + 16'd1;
                        end
                    end
                end
                S_STAT_OUT: begin
                    if (w_out_accept) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
